// File: rtl/gemm_stream_engine.sv
// Weight-stationary ROWS x COLS systolic GEMM: res[i] = sum_j act[j]*W[j][i], one vector per cycle.
// Latency: vector accepted in cycle t -> res_valid in cycle t+ROWS+COLS (+1 per stalled cycle).
// Backpressure: res_valid && !res_ready freezes the whole pipeline; act_ready drops, result holds.
//
// Ports: clk/reset (sync, active-high); w_valid/w_ready/w_row load weight rows 0..ROWS-1 in order;
// act_valid/act_ready/act_in feed activation vectors; res_valid/res_ready/res_out return results;
// weights_loaded = full matrix resident; busy = any vector in flight or result pending.
// Optional: define GEMM_SATURATE_EN to clamp each PE adder at 2^ACC_WIDTH-1 instead of wrapping.
module gemm_stream_engine #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        w_valid,
    output logic                        w_ready,
    input  logic [COLS*DATA_WIDTH-1:0]  w_row,
    input  logic                        act_valid,
    output logic                        act_ready,
    input  logic [ROWS*DATA_WIDTH-1:0]  act_in,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [COLS*ACC_WIDTH-1:0]   res_out,
    output logic                        weights_loaded,
    output logic                        busy
);
    localparam int PW    = 2 * DATA_WIDTH;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DEPTH = ROWS + COLS;
    localparam int FW    = $clog2(DEPTH + 1);
    localparam int VW    = DEPTH - 1;

    typedef enum logic [1:0] {EMPTY, LOADING, READY} state_t;

    state_t                state;
    logic [RW-1:0]         row_cnt;
    logic [RW-1:0]         w_idx;
    logic [FW-1:0]         in_flight;
    logic                  advance;
    logic                  act_fire;
    logic                  w_fire;
    logic                  res_fire;
    logic [VW-1:0]         vld_sr;
    logic [DATA_WIDTH-1:0] w_mem  [ROWS][COLS];
    logic [DATA_WIDTH-1:0] a_left [ROWS][COLS];  // activation entering each PE
    logic [DATA_WIDTH-1:0] h      [ROWS][COLS];  // activation passed to the right
    logic [ACC_WIDTH-1:0]  p_up   [ROWS][COLS];  // partial sum entering from above
    logic [ACC_WIDTH-1:0]  p      [ROWS][COLS];
    logic [ACC_WIDTH-1:0]  col_out [COLS];

    function automatic logic [ACC_WIDTH-1:0] mac(input logic [ACC_WIDTH-1:0]  acc,
                                                 input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] w);
        logic [PW-1:0] prod;
        prod = a * w;
`ifdef GEMM_SATURATE_EN
        begin
            localparam int SW = ((ACC_WIDTH > PW) ? ACC_WIDTH : PW) + 1;
            logic [SW-1:0] sum;
            sum = SW'(acc) + SW'(prod);
            mac = (sum > SW'({ACC_WIDTH{1'b1}})) ? '1 : sum[ACC_WIDTH-1:0];
        end
`else
        mac = acc + ACC_WIDTH'(prod);
`endif
    endfunction

    assign advance   = !(res_valid && !res_ready);
    assign act_ready = (state == READY) && advance;
    // A reload only starts on a drained pipeline and yields to a waiting activation.
    assign w_ready   = (state != READY) || (in_flight == '0 && !res_valid && !act_valid);
    assign act_fire  = act_valid && act_ready;
    assign w_fire    = w_valid && w_ready;
    assign res_fire  = res_valid && res_ready;
    assign busy      = (in_flight != '0);
    // A beat seen outside LOADING always starts a fresh matrix at row 0.
    assign w_idx     = (state == LOADING) ? row_cnt : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= EMPTY;
            row_cnt        <= '0;
            weights_loaded <= 1'b0;
            for (int j = 0; j < ROWS; j++)
                for (int i = 0; i < COLS; i++)
                    w_mem[j][i] <= '0;
        end else if (w_fire) begin
            for (int j = 0; j < ROWS; j++)
                if (w_idx == RW'(j))
                    for (int i = 0; i < COLS; i++)
                        w_mem[j][i] <= w_row[i*DATA_WIDTH +: DATA_WIDTH];
            if (w_idx == RW'(ROWS - 1)) begin
                state          <= READY;
                row_cnt        <= '0;
                weights_loaded <= 1'b1;
            end else begin
                state          <= LOADING;
                row_cnt        <= w_idx + RW'(1);
                weights_loaded <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            in_flight <= '0;
        else if (act_fire && !res_fire)
            in_flight <= in_flight + FW'(1);
        else if (!act_fire && res_fire)
            in_flight <= in_flight - FW'(1);
    end

    // Row j sees its activation j cycles late so PE(j,i) works on a vector at step j+i.
    for (genvar j = 0; j < ROWS; j++) begin : g_row
        if (j == 0) begin : g_noskew
            assign a_left[0][0] = act_in[DATA_WIDTH-1:0];
        end else begin : g_skew
            logic [DATA_WIDTH-1:0] sk [j];
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int k = 0; k < j; k++) sk[k] <= '0;
                end else if (advance) begin
                    sk[0] <= act_in[j*DATA_WIDTH +: DATA_WIDTH];
                    for (int k = 1; k < j; k++) sk[k] <= sk[k-1];
                end
            end
            assign a_left[j][0] = sk[j-1];
        end
        for (genvar i = 1; i < COLS; i++) begin : g_h
            assign a_left[j][i] = h[j][i-1];
        end
        for (genvar i = 0; i < COLS; i++) begin : g_pup
            if (j == 0) begin : g_top
                assign p_up[0][i] = '0;
            end else begin : g_mid
                assign p_up[j][i] = p[j-1][i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < ROWS; j++)
                for (int i = 0; i < COLS; i++) begin
                    h[j][i] <= '0;
                    p[j][i] <= '0;
                end
        end else if (advance) begin
            for (int j = 0; j < ROWS; j++)
                for (int i = 0; i < COLS; i++) begin
                    h[j][i] <= a_left[j][i];
                    p[j][i] <= mac(p_up[j][i], a_left[j][i], w_mem[j][i]);
                end
        end
    end

    // Column i finishes at step ROWS-1+i; delay the early columns so all line up.
    for (genvar i = 0; i < COLS; i++) begin : g_col
        localparam int L = COLS - 1 - i;
        if (L == 0) begin : g_nodsk
            assign col_out[i] = p[ROWS-1][i];
        end else begin : g_dsk
            logic [ACC_WIDTH-1:0] dq [L];
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int k = 0; k < L; k++) dq[k] <= '0;
                end else if (advance) begin
                    dq[0] <= p[ROWS-1][i];
                    for (int k = 1; k < L; k++) dq[k] <= dq[k-1];
                end
            end
            assign col_out[i] = dq[L-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_sr    <= '0;
            res_valid <= 1'b0;
            res_out   <= '0;
        end else if (advance) begin
            vld_sr[0] <= act_fire;
            for (int k = 1; k < VW; k++) vld_sr[k] <= vld_sr[k-1];
            res_valid <= vld_sr[VW-1];
            if (vld_sr[VW-1])
                for (int i = 0; i < COLS; i++)
                    res_out[i*ACC_WIDTH +: ACC_WIDTH] <= col_out[i];
        end
    end
endmodule

// File: tb/tb_gemm_stream_engine.sv
module tb_gemm_stream_engine;
    localparam int R  = 2;
    localparam int C  = 2;
    localparam int DW = 8;
    localparam int AW = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            w_valid, w_ready, act_valid, act_ready, res_valid, res_ready;
    logic [C*DW-1:0] w_row;
    logic [R*DW-1:0] act_in;
    logic [C*AW-1:0] res_out;
    logic            weights_loaded, busy;

    gemm_stream_engine #(.ROWS(R), .COLS(C), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row),
        .act_valid(act_valid), .act_ready(act_ready), .act_in(act_in),
        .res_valid(res_valid), .res_ready(res_ready), .res_out(res_out),
        .weights_loaded(weights_loaded), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    endtask

    function automatic logic [C*DW-1:0] wr(input logic [7:0] e0, input logic [7:0] e1);
        return {e1, e0};
    endfunction
    function automatic logic [C*AW-1:0] rv(input logic [15:0] e0, input logic [15:0] e1);
        return {e1, e0};
    endfunction

`ifdef GEMM_SATURATE_EN
    localparam logic [C*AW-1:0] EXP_BIG = {16'd65535, 16'd65535};
`else
    localparam logic [C*AW-1:0] EXP_BIG = {16'd64514, 16'd64514};
`endif

    // Reference model: weight matrix, load progress, expected results in order.
    int              m_w [R][C];
    int              m_phase = 0;   // 0 empty, 1 loading, 2 ready
    int              m_row = 0;
    int              m_cnt = 0;
    bit              m_loaded = 1'b0;
    logic [C*AW-1:0] exp_q [$];

    function automatic logic [C*AW-1:0] model_res(input logic [R*DW-1:0] a);
        logic [C*AW-1:0] r;
        longint s;
        r = '0;
        for (int i = 0; i < C; i++) begin
            s = 0;
            for (int j = 0; j < R; j++) begin
                s += longint'(a[j*DW +: DW]) * longint'(m_w[j][i]);
`ifdef GEMM_SATURATE_EN
                if (s > 65535) s = 65535;
`else
                s = s % 65536;
`endif
            end
            r[i*AW +: AW] = AW'(s);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            m_phase = 0; m_row = 0; m_cnt = 0; m_loaded = 1'b0;
            for (int j = 0; j < R; j++)
                for (int i = 0; i < C; i++) m_w[j][i] = 0;
            exp_q.delete();
        end else begin
            chk("busy", busy, m_cnt != 0);
            chk("weights_loaded", weights_loaded, m_loaded);
            if (m_phase != 2) begin
                chk("act_ready_unloaded", act_ready, 1'b0);
                chk("w_ready_unloaded", w_ready, 1'b1);
            end
            if (res_valid) begin
                chk("res_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) chk("res_out", res_out, exp_q[0]);
            end
            if (act_valid && act_ready) begin
                exp_q.push_back(model_res(act_in));
                m_cnt++;
            end
            if (res_valid && res_ready && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                m_cnt--;
            end
            if (w_valid && w_ready) begin
                if (m_phase == 2) begin
                    chk("reload_idle", m_cnt, 0);
                    m_row = 0;
                end
                for (int i = 0; i < C; i++) m_w[m_row][i] = int'(w_row[i*DW +: DW]);
                if (m_row == R - 1) begin
                    m_phase = 2; m_loaded = 1'b1; m_row = 0;
                end else begin
                    m_phase = 1; m_loaded = 1'b0; m_row++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load_row(input logic [C*DW-1:0] r);
        bit ok;
        tick();
        w_valid = 1'b1;
        w_row   = r;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (w_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("w_ready_timeout", w_ready, 1'b1);
    endtask

    task automatic load_w(input logic [C*DW-1:0] r0, input logic [C*DW-1:0] r1);
        load_row(r0);
        load_row(r1);
        tick();
        w_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_act(input logic [R*DW-1:0] a);
        bit ok;
        tick();
        act_valid = 1'b1;
        act_in    = a;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (act_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("act_ready_timeout", act_ready, 1'b1);
    endtask

    task automatic wait_res(output int lat);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (res_valid) begin lat = k; break; end
        end
    endtask

    initial begin
        int lat;
        int stale;
        w_valid = 0; act_valid = 0; res_ready = 1; w_row = '0; act_in = '0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_res_out", res_out, '0);
        chk("rst_w_ready", w_ready, 1'b1);
        chk("rst_act_ready", act_ready, 1'b0);
        chk("rst_loaded", weights_loaded, 1'b0);
        chk("rst_busy", busy, 1'b0);

        // W = [[3,0],[0,2]]
        load_w(wr(3, 0), wr(0, 2));
        chk("loaded_after_load", weights_loaded, 1'b1);

        // Single vector: latency ROWS+COLS = 4
        send_act(wr(2, 5));
        tick(); act_valid = 1'b0;
        wait_res(lat);
        chk("lat_single", lat, 4);
        chk("res_single", res_out, rv(6, 10));
        @(negedge clk);
        chk("busy_after_single", busy, 1'b0);

        // Back-to-back vectors
        send_act(wr(2, 5));
        send_act(wr(3, 2));
        tick(); act_valid = 1'b0;
        wait_res(lat);
        chk("lat_b2b", lat, 3);
        chk("res_b2b_0", res_out, rv(6, 10));
        @(negedge clk);
        chk("res_b2b_1_vld", res_valid, 1'b1);
        chk("res_b2b_1", res_out, rv(9, 4));
        chk("busy_b2b_pending", busy, 1'b1);
        @(negedge clk);
        chk("busy_b2b_done", busy, 1'b0);
        chk("res_b2b_idle", res_valid, 1'b0);

        // Result backpressure for 3 cycles
        tick(); res_ready = 1'b0;
        send_act(wr(2, 5));
        send_act(wr(3, 2));
        tick(); act_valid = 1'b0;
        wait_res(lat);
        chk("lat_stall", lat, 3);
        for (int s = 0; s < 3; s++) begin
            if (s > 0) @(negedge clk);
            chk("stall_vld", res_valid, 1'b1);
            chk("stall_hold", res_out, rv(6, 10));
            chk("stall_act_ready", act_ready, 1'b0);
        end
        tick(); res_ready = 1'b1;
        @(negedge clk);
        chk("release_0", res_out, rv(6, 10));
        @(negedge clk);
        chk("release_1_vld", res_valid, 1'b1);
        chk("release_1", res_out, rv(9, 4));
        @(negedge clk);
        chk("release_idle", res_valid, 1'b0);

        // Overflow: all weights 255, act [255,255]
        load_w(wr(255, 255), wr(255, 255));
        send_act(wr(255, 255));
        tick(); act_valid = 1'b0;
        wait_res(lat);
        chk("lat_big", lat, 4);
        chk("res_big", res_out, EXP_BIG);
        @(negedge clk);

        // Weight and activation together in READY: activation wins
        tick();
        w_valid = 1'b1; w_row = wr(1, 1);
        act_valid = 1'b1; act_in = wr(1, 2);
        @(negedge clk);
        chk("prio_w_ready", w_ready, 1'b0);
        chk("prio_act_ready", act_ready, 1'b1);
        tick(); act_valid = 1'b0;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (res_valid) chk("res_prio", res_out, rv(765, 765));
            if (w_ready) begin lat = k; break; end
        end
        chk("reload_started", w_ready, 1'b1);
        tick(); w_row = wr(1, 1);
        @(negedge clk);
        chk("loading_act_ready", act_ready, 1'b0);
        chk("loading_loaded", weights_loaded, 1'b0);
        tick(); w_valid = 1'b0;
        @(negedge clk);
        chk("reloaded", weights_loaded, 1'b1);
        send_act(wr(4, 6));
        tick(); act_valid = 1'b0;
        wait_res(lat);
        chk("lat_reload", lat, 4);
        chk("res_reload", res_out, rv(10, 10));
        @(negedge clk);

        // Reset with two vectors in flight
        send_act(wr(4, 6));
        send_act(wr(1, 2));
        tick(); act_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        tick(); reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_res_valid", res_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_loaded", weights_loaded, 1'b0);
        chk("mid_rst_w_ready", w_ready, 1'b1);
        chk("mid_rst_act_ready", act_ready, 1'b0);
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            if (res_valid) stale++;
        end
        chk("no_stale_result", stale, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d passed %0d", n_chk, n_pass);
        $fatal(1);
    end
endmodule
